// File: rtl/load_store_unit_if.sv
// Data-bus port bundle between the load/store unit and memory.
// master: the LSU issuing requests; slave: the memory responder.
interface load_store_unit_if;
   logic        bus_req_valid;
   logic        bus_req_ready;
   logic        bus_req_we;
   logic [31:0] bus_req_addr;
   logic [31:0] bus_req_wdata;
   logic [3:0]  bus_req_wstrb;
   logic        bus_rsp_valid;
   logic [31:0] bus_rsp_rdata;
   logic        bus_rsp_err;

   modport master (
      output bus_req_valid,
      output bus_req_we,
      output bus_req_addr,
      output bus_req_wdata,
      output bus_req_wstrb,
      input  bus_req_ready,
      input  bus_rsp_valid,
      input  bus_rsp_rdata,
      input  bus_rsp_err
   );

   modport slave (
      input  bus_req_valid,
      input  bus_req_we,
      input  bus_req_addr,
      input  bus_req_wdata,
      input  bus_req_wstrb,
      output bus_req_ready,
      output bus_rsp_valid,
      output bus_rsp_rdata,
      output bus_rsp_err
   );
endinterface

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: one bus transaction per load/store.
// Option LSU_MISALIGN_TRAP_EN traps misaligned accesses instead of aligning.
module load_store_unit #(
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rd_en,
   input  logic        wr_en,
   input  logic [2:0]  mem_mode,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        stall_o,
   output logic [31:0] rdata_o,
   output logic        rdata_valid_o,
   output logic        err_o,
   output logic        misalign_o,
   load_store_unit_if.master bus
);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      RSP,
      DONE
   } state_e;

   localparam logic [8:0] TO_LIM = 9'(TIMEOUT_CYC);

   state_e      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [31:0] addr_q, addr_d;
   logic [1:0]  off_q, off_d;
   logic [2:0]  mode_q, mode_d;
   logic        we_q, we_d;
   logic [31:0] wdat_q, wdat_d;
   logic [3:0]  strb_q, strb_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;
   logic        vld_q, vld_d;
`ifdef LSU_MISALIGN_TRAP_EN
   logic        mis_q, mis_d;
   logic        misal;
`endif

   logic        legal;
   logic        is_b, is_h, is_w;
   logic [1:0]  off_a;
   logic [3:0]  strb_n;
   logic [31:0] wdat_n;
   logic [31:0] sh;
   logic [31:0] ld_fmt;
   logic [8:0]  cnt_inc;
   logic        tmo;

   // A store wins when both enables are high, so legality follows wr_en
   always_comb begin
      legal = 1'b0;
      if (wr_en) begin
         legal = (mem_mode <= 3'b010);
      end else if (rd_en) begin
         legal = (mem_mode <= 3'b100);
      end
      is_b = (mem_mode == 3'b000) || (mem_mode == 3'b011);
      is_h = (mem_mode == 3'b001) || (mem_mode == 3'b100);
      is_w = (mem_mode == 3'b010);
      off_a = addr[1:0];
      if (is_h) off_a[0] = 1'b0;
      if (is_w) off_a = 2'b00;
   end

`ifdef LSU_MISALIGN_TRAP_EN
   assign misal = (is_h && addr[0]) || (is_w && (addr[1:0] != 2'b00));
`endif

   always_comb begin
      strb_n = 4'b1111;
      wdat_n = wdata;
      unique case (1'b1)
         is_b: begin
            strb_n = 4'b0001 << off_a;
            wdat_n = {4{wdata[7:0]}};
         end
         is_h: begin
            strb_n = 4'b0011 << {off_a[1], 1'b0};
            wdat_n = {2{wdata[15:0]}};
         end
         default: begin
            strb_n = 4'b1111;
            wdat_n = wdata;
         end
      endcase
   end

   always_comb begin
      sh = bus.bus_rsp_rdata >> {off_q, 3'b000};
      unique case (mode_q)
         3'b000:  ld_fmt = {{24{sh[7]}}, sh[7:0]};
         3'b001:  ld_fmt = {{16{sh[15]}}, sh[15:0]};
         3'b011:  ld_fmt = {24'h0, sh[7:0]};
         3'b100:  ld_fmt = {16'h0, sh[15:0]};
         default: ld_fmt = bus.bus_rsp_rdata;
      endcase
   end

   assign cnt_inc = {1'b0, cnt_q} + 9'd1;
   assign tmo     = (cnt_inc >= TO_LIM);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      off_d   = off_q;
      mode_d  = mode_q;
      we_d    = we_q;
      wdat_d  = wdat_q;
      strb_d  = strb_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      vld_d   = vld_q;
`ifdef LSU_MISALIGN_TRAP_EN
      mis_d   = mis_q;
`endif
      stall_o = 1'b0;
      unique case (state_q)
         IDLE: begin
            cnt_d = 8'd0;
            if (legal) begin
               stall_o = 1'b1;
               addr_d  = {addr[31:2], 2'b00};
               off_d   = off_a;
               mode_d  = mem_mode;
               we_d    = wr_en;
               wdat_d  = wdat_n;
               strb_d  = wr_en ? strb_n : 4'b0000;
               err_d   = 1'b0;
               vld_d   = 1'b0;
               state_d = REQ;
`ifdef LSU_MISALIGN_TRAP_EN
               mis_d = misal;
               if (misal) state_d = DONE;
`endif
            end
         end
         REQ: begin
            stall_o = 1'b1;
            cnt_d   = cnt_inc[7:0];
            if (bus.bus_req_ready) begin
               state_d = RSP;
            end else if (tmo) begin
               err_d   = 1'b1;
               rdata_d = 32'h0;
               state_d = DONE;
            end
         end
         RSP: begin
            stall_o = 1'b1;
            cnt_d   = cnt_inc[7:0];
            if (bus.bus_rsp_valid) begin
               err_d   = bus.bus_rsp_err;
               vld_d   = !we_q;
               if (!we_q) rdata_d = bus.bus_rsp_err ? 32'h0 : ld_fmt;
               state_d = DONE;
            end else if (tmo) begin
               err_d   = 1'b1;
               rdata_d = 32'h0;
               state_d = DONE;
            end
         end
         DONE: begin
            cnt_d   = 8'd0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= 8'd0;
         addr_q  <= 32'h0;
         off_q   <= 2'b00;
         mode_q  <= 3'b000;
         we_q    <= 1'b0;
         wdat_q  <= 32'h0;
         strb_q  <= 4'b0000;
         rdata_q <= 32'h0;
         err_q   <= 1'b0;
         vld_q   <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
         mis_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         off_q   <= off_d;
         mode_q  <= mode_d;
         we_q    <= we_d;
         wdat_q  <= wdat_d;
         strb_q  <= strb_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         vld_q   <= vld_d;
`ifdef LSU_MISALIGN_TRAP_EN
         mis_q   <= mis_d;
`endif
      end
   end

   assign rdata_o       = rdata_q;
   assign rdata_valid_o = (state_q == DONE) && vld_q;
   assign err_o         = (state_q == DONE) && err_q;
`ifdef LSU_MISALIGN_TRAP_EN
   assign misalign_o    = (state_q == DONE) && mis_q;
`else
   assign misalign_o    = 1'b0;
`endif

   assign bus.bus_req_valid = (state_q == REQ);
   assign bus.bus_req_we    = we_q;
   assign bus.bus_req_addr  = addr_q;
   assign bus.bus_req_wdata = wdat_q;
   assign bus.bus_req_wstrb = strb_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases plus random accesses
// checked against an arithmetic model of the memory-stage rules.
module tb_load_store_unit;
   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rd_en = 1'b0;
   logic        wr_en = 1'b0;
   logic [2:0]  mem_mode = 3'b000;
   logic [31:0] addr = 32'h0;
   logic [31:0] wdata = 32'h0;
   logic        stall_o;
   logic [31:0] rdata_o;
   logic        rdata_valid_o;
   logic        err_o;
   logic        misalign_o;

   int tests = 0;
   int fails = 0;
   logic [31:0] exp_rdata = 32'h0;

   load_store_unit_if bus_if ();

   load_store_unit #(.TIMEOUT_CYC(TO)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .rd_en         (rd_en),
      .wr_en         (wr_en),
      .mem_mode      (mem_mode),
      .addr          (addr),
      .wdata         (wdata),
      .stall_o       (stall_o),
      .rdata_o       (rdata_o),
      .rdata_valid_o (rdata_valid_o),
      .err_o         (err_o),
      .misalign_o    (misalign_o),
      .bus           (bus_if.master)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int m_bytes(input logic [2:0] m);
      if (m == 3'd0 || m == 3'd3) return 1;
      if (m == 3'd1 || m == 3'd4) return 2;
      return 4;
   endfunction

   function automatic logic [31:0] m_load(input logic [2:0] m,
                                          input int unsigned off,
                                          input logic [31:0] w);
      int unsigned v;
      v = w;
      if (m_bytes(m) == 1) begin
         v = (w >> (8 * off)) % 256;
         if (m == 3'd0 && v >= 128) v = v + 32'hFFFF_FF00;
      end else if (m_bytes(m) == 2) begin
         v = (w >> (8 * off)) % 65536;
         if (m == 3'd1 && v >= 32768) v = v + 32'hFFFF_0000;
      end
      return v;
   endfunction

   task automatic drop();
      rd_en = 1'b0;
      wr_en = 1'b0;
   endtask

   task automatic run(input logic rd, input logic wr, input logic [2:0] m,
                      input logic [31:0] a, input logic [31:0] wd,
                      input int dr, input int ds,
                      input logic [31:0] rw, input logic re);
      bit          legal;
      bit          st;
      bit          mis;
      int unsigned nb, a_al, off;
      logic [31:0] e_addr, e_wd;
      logic [3:0]  e_strb;
      st    = wr;
      legal = wr ? (m <= 3'd2) : (rd && m <= 3'd4);
      nb    = m_bytes(m);
      mis   = (a % nb) != 0;
      a_al  = a - (a % nb);
      off   = a_al % 4;
      e_addr = a_al - off;
      e_strb = !st ? 4'd0 : nb == 1 ? 4'(1 << off) :
               nb == 2 ? 4'(3 << off) : 4'hF;
      e_wd = nb == 1 ? (wd % 256) * 32'h0101_0101 :
             nb == 2 ? (wd % 65536) * 32'h0001_0001 : wd;

      @(negedge clk);
      rd_en = rd; wr_en = wr; mem_mode = m; addr = a; wdata = wd;
      #1 chk("stall_c0", stall_o, legal);
      if (!legal) begin
         @(negedge clk);
         chk("ill_valid", bus_if.bus_req_valid, 1'b0);
         chk("ill_stall", stall_o, 1'b0);
         chk("ill_rdv", rdata_valid_o, 1'b0);
         drop();
         return;
      end
`ifdef LSU_MISALIGN_TRAP_EN
      if (mis) begin
         @(negedge clk);
         chk("mis_pulse", misalign_o, 1'b1);
         chk("mis_valid", bus_if.bus_req_valid, 1'b0);
         chk("mis_rdv", rdata_valid_o, 1'b0);
         chk("mis_rdata", rdata_o, exp_rdata);
         drop();
         @(negedge clk);
         chk("mis_end", misalign_o, 1'b0);
         return;
      end
`else
      if (mis) chk("nomis_pulse", misalign_o, 1'b0);
`endif
      for (int c = 0; c <= dr; c++) begin
         @(negedge clk);
         chk("req_valid", bus_if.bus_req_valid, 1'b1);
         chk("req_stall", stall_o, 1'b1);
         chk("req_addr", bus_if.bus_req_addr, e_addr);
         chk("req_wstrb", 32'(bus_if.bus_req_wstrb), 32'(e_strb));
         chk("req_we", bus_if.bus_req_we, st);
         if (st) chk("req_wdata", bus_if.bus_req_wdata, e_wd);
         bus_if.bus_req_ready = (c == dr);
      end
      for (int c = 0; c <= ds; c++) begin
         @(negedge clk);
         bus_if.bus_req_ready = 1'b0;
         chk("rsp_valid", bus_if.bus_req_valid, 1'b0);
         chk("rsp_stall", stall_o, 1'b1);
         bus_if.bus_rsp_valid = (c == ds);
         bus_if.bus_rsp_rdata = (c == ds) ? rw : $urandom;
         bus_if.bus_rsp_err   = (c == ds) ? re : 1'b0;
      end
      @(negedge clk);
      bus_if.bus_rsp_valid = 1'b0;
      bus_if.bus_rsp_err   = 1'b0;
      if (!st) exp_rdata = re ? 32'h0 : m_load(m, off, rw);
      chk("done_stall", stall_o, 1'b0);
      chk("done_rdv", rdata_valid_o, !st);
      chk("done_err", err_o, re);
      chk("done_rdata", rdata_o, exp_rdata);
      drop();
      @(negedge clk);
      chk("idle_rdv", rdata_valid_o, 1'b0);
      chk("idle_err", err_o, 1'b0);
      chk("idle_stall", stall_o, 1'b0);
   endtask

   initial begin
      int cyc;
      bool_init: begin
         bus_if.bus_req_ready = 1'b0;
         bus_if.bus_rsp_valid = 1'b0;
         bus_if.bus_rsp_rdata = 32'h0;
         bus_if.bus_rsp_err   = 1'b0;
      end
      #12;
      chk("rst_stall", stall_o, 1'b0);
      chk("rst_rdata", rdata_o, 32'h0);
      chk("rst_valid", bus_if.bus_req_valid, 1'b0);
      chk("rst_addr", bus_if.bus_req_addr, 32'h0);
      chk("rst_wstrb", 32'(bus_if.bus_req_wstrb), 32'h0);
      chk("rst_err", err_o, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      run(1, 0, 3'd2, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF, 0);
      chk("lw_const", rdata_o, 32'hDEADBEEF);
      run(0, 1, 3'd0, 32'h103, 32'hA5, 0, 0, 32'h0, 0);
      chk("sb_hold", rdata_o, 32'hDEADBEEF);
      run(1, 0, 3'd0, 32'h102, 32'h0, 0, 0, 32'h0080_0000, 0);
      chk("lb_const", rdata_o, 32'hFFFF_FF80);
      run(1, 0, 3'd4, 32'h102, 32'h0, 0, 0, 32'h8001_0000, 0);
      chk("lhu_const", rdata_o, 32'h0000_8001);
      run(1, 0, 3'd2, 32'h300, 32'h0, 3, 0, 32'h1234_5678, 0);
      run(1, 0, 3'd2, 32'h102, 32'h0, 0, 1, 32'hCAFE_F00D, 0);
      run(1, 1, 3'd2, 32'h40, 32'h5555_AAAA, 1, 0, 32'h0, 0);
      run(1, 0, 3'd1, 32'h46, 32'h0, 0, 0, 32'hFFFF_FFFF, 1);
      run(1, 0, 3'd6, 32'h50, 32'h0, 0, 0, 32'h0, 0);
      run(0, 1, 3'd3, 32'h50, 32'h0, 0, 0, 32'h0, 0);

      // Timeout: ready given, response never returned
      run(1, 0, 3'd2, 32'h80, 32'h0, 0, 0, 32'h0BAD_CAFE, 0);
      @(negedge clk);
      rd_en = 1'b1; mem_mode = 3'd2; addr = 32'h200;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
         bus_if.bus_req_ready = (cyc == 1);
      end while (!err_o && cyc < 4 * TO);
      bus_if.bus_req_ready = 1'b0;
      exp_rdata = 32'h0;
      chk("tmo_err", err_o, 1'b1);
      chk("tmo_cycle", cyc, TO + 1);
      chk("tmo_rdata", rdata_o, exp_rdata);
      chk("tmo_rdv", rdata_valid_o, 1'b0);
      drop();
      @(negedge clk);
      chk("tmo_idle", bus_if.bus_req_valid, 1'b0);
      chk("tmo_err_end", err_o, 1'b0);

      // Reset while waiting for the response
      run(1, 0, 3'd2, 32'h90, 32'h0, 0, 0, 32'h7777_1111, 0);
      @(negedge clk);
      rd_en = 1'b1; mem_mode = 3'd2; addr = 32'h94;
      @(negedge clk);
      bus_if.bus_req_ready = 1'b1;
      @(negedge clk);
      bus_if.bus_req_ready = 1'b0;
      chk("pre_rst_stall", stall_o, 1'b1);
      #2 rst_n = 1'b0;
      drop();
      #1;
      exp_rdata = 32'h0;
      chk("arst_stall", stall_o, 1'b0);
      chk("arst_valid", bus_if.bus_req_valid, 1'b0);
      chk("arst_rdata", rdata_o, exp_rdata);
      @(negedge clk);
      rst_n = 1'b1;
      bus_if.bus_rsp_valid = 1'b1;
      bus_if.bus_rsp_rdata = 32'h1357_9BDF;
      @(negedge clk);
      bus_if.bus_rsp_valid = 1'b0;
      chk("late_rdv", rdata_valid_o, 1'b0);
      chk("late_rdata", rdata_o, exp_rdata);
      chk("late_stall", stall_o, 1'b0);

      for (int i = 0; i < 40; i++) begin
         run(1'($urandom), 1'($urandom), 3'($urandom), $urandom, $urandom,
             int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
             $urandom, ($urandom_range(0, 7) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
